// File: rtl/teclado_escaner.sv
// teclado_escaner: FILAS x COLS matrix-keypad scanner. Drives one-hot column
// strobes, samples synchronised rows at the end of each column slot, classifies
// each full frame (none / single key / multiple keys), debounces frame results
// and tracks the accepted keypad state with a rollover-lockout FSM.
module teclado_escaner #(
    parameter int FILAS    = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    localparam int CODE_W  = $clog2(FILAS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FILAS-1:0]  fila,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] codigo,
    output logic              tecla_valida,
    output logic              pulso,
    output logic              multiple
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(COLS);
    localparam int unsigned FILAS_U = FILAS;

    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;
    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_LOCK} state_t;

    logic [FILAS-1:0]  r_sync1, r_sync2;
    logic [SLOT_W-1:0] r_slot;
    logic [IDX_W-1:0]  r_col_idx;
    logic [1:0]        r_hits;
    logic [CODE_W-1:0] r_first_code;
    res_t              r_cand_kind;
    logic [CODE_W-1:0] r_cand_code;
    logic [7:0]        r_cnt;
    state_t            r_state, w_next;
    logic [CODE_W-1:0] r_codigo;
    logic              r_pulso;

    logic              w_slot_last, w_col_last, w_frame_end;
    logic [1:0]        w_pop;
    logic              w_found;
    int unsigned       w_row;
    logic [CODE_W-1:0] w_col_code;
    logic [2:0]        w_sum;
    logic [1:0]        w_hits_sum;
    logic [CODE_W-1:0] w_first;
    res_t              w_res_kind;
    logic [CODE_W-1:0] w_res_code;
    logic              w_same;
    logic [7:0]        w_cnt_next;
    logic              w_accept;
    logic              w_new_key;

    assign w_slot_last = (r_slot == SLOT_W'(SCAN_DIV - 1));
    assign w_col_last  = (r_col_idx == IDX_W'(COLS - 1));
    assign w_frame_end = w_slot_last && w_col_last;

    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= fila;
            r_sync2 <= r_sync1;
        end
    end

    // Slot counter and column index; column advances when a slot wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot    <= '0;
            r_col_idx <= '0;
        end else if (w_slot_last) begin
            r_slot    <= '0;
            r_col_idx <= w_col_last ? '0 : r_col_idx + 1'b1;
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    // One-hot column drive
    always_comb begin
        col = COLS'(1) << r_col_idx;
    end

    // Row sample of the current column merged with the frame accumulator;
    // the frame result already includes the last column being sampled now
    always_comb begin
        w_pop   = 2'd0;
        w_found = 1'b0;
        w_row   = 0;
        for (int unsigned i = 0; i < FILAS_U; i++) begin
            if (r_sync2[i]) begin
                if (w_pop != 2'd2) w_pop = w_pop + 2'd1;
                if (!w_found) begin
                    w_row   = i;
                    w_found = 1'b1;
                end
            end
        end
        w_col_code = CODE_W'(32'(r_col_idx) * FILAS_U + w_row);
        w_sum      = 3'(r_hits) + 3'(w_pop);
        w_hits_sum = (w_sum > 3'd2) ? 2'd2 : w_sum[1:0];
        w_first    = (r_hits == 2'd0) ? w_col_code : r_first_code;
        case (w_hits_sum)
            2'd0:    w_res_kind = RES_NONE;
            2'd1:    w_res_kind = RES_SINGLE;
            default: w_res_kind = RES_MULTI;
        endcase
        w_res_code = (w_res_kind == RES_SINGLE) ? w_first : '0;
    end

    // Per-frame hit accumulator, cleared at each frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hits       <= '0;
            r_first_code <= '0;
        end else if (w_slot_last) begin
            if (w_frame_end) begin
                r_hits       <= '0;
                r_first_code <= '0;
            end else begin
                r_hits       <= w_hits_sum;
                r_first_code <= w_first;
            end
        end
    end

    // Debounce: count consecutive identical frame results, saturating
    always_comb begin
        w_same     = (w_res_kind == r_cand_kind) && (w_res_code == r_cand_code);
        w_cnt_next = 8'd1;
        if (w_same) w_cnt_next = (r_cnt == 8'(DEBOUNCE)) ? r_cnt : r_cnt + 8'd1;
        w_accept   = w_frame_end && (w_cnt_next == 8'(DEBOUNCE));
    end

    // Candidate register and debounce counter, updated once per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand_kind <= RES_NONE;
            r_cand_code <= '0;
            r_cnt       <= '0;
        end else if (w_frame_end) begin
            r_cand_kind <= w_res_kind;
            r_cand_code <= w_res_code;
            r_cnt       <= w_cnt_next;
        end
    end

    // FSM state register plus registered code and press strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_codigo <= '0;
            r_pulso  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pulso <= w_new_key;
            if (w_new_key) r_codigo <= w_res_code;
        end
    end

    // FSM next state on accepted results; a held saturated key re-accepts harmlessly
    always_comb begin
        w_next    = r_state;
        w_new_key = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_res_kind == RES_SINGLE) begin
                        w_next    = ST_PRESSED;
                        w_new_key = 1'b1;
                    end else if (w_res_kind == RES_MULTI) begin
                        w_next = ST_LOCK;
                    end
                end
                ST_PRESSED: begin
                    if (w_res_kind == RES_NONE) begin
                        w_next = ST_IDLE;
                    end else if (w_res_kind == RES_MULTI) begin
                        w_next = ST_LOCK;
                    end else if (w_res_code != r_codigo) begin
                        w_new_key = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (w_res_kind == RES_NONE) w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        tecla_valida = (r_state == ST_PRESSED);
        multiple     = (r_state == ST_LOCK);
        codigo       = r_codigo;
        pulso        = r_pulso;
    end

endmodule

// File: tb/tb_teclado_escaner.sv
// Bench for teclado_escaner: a keypad model drives rows from the column strobe;
// results are checked frame-by-frame against constant tables, hand sequences
// and a frame-level reference model (debounce as a sliding history window).
module tb_teclado_escaner;

    localparam int FILAS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fila, col, codigo;
    logic       tecla_valida, pulso, multiple;
    logic [15:0] keys;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] k;
        bit          tv;
        bit          mu;
        logic [3:0]  code;
        bit          p;
    } vec_t;
    vec_t tbl[$];

    // model state: 0 idle, 1 pressed, 2 lock; results: -1 none, -2 multi, else code
    int m_state, m_code;
    bit m_pulso;
    int m_hist[$];

    always #5 clk = ~clk;

    teclado_escaner #(.FILAS(FILAS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst(rst), .fila(fila), .col(col), .codigo(codigo),
        .tecla_valida(tecla_valida), .pulso(pulso), .multiple(multiple)
    );

    // keypad: key k sits at column k/4, row k%4
    always_comb begin
        fila = '0;
        for (int c = 0; c < 4; c++)
            if (col[c])
                for (int r = 0; r < 4; r++)
                    if (keys[c*4+r]) fila[r] = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input bit tv, input bit mu, input int code, input bit p);
        chk({tag, "_tv"}, 32'(tecla_valida), 32'(tv));
        chk({tag, "_mult"}, 32'(multiple), 32'(mu));
        chk({tag, "_code"}, 32'(codigo), 32'(code));
        chk({tag, "_pulso"}, 32'(pulso), 32'(p));
    endtask

    function automatic int classify(input logic [15:0] k);
        int n = $countones(k);
        int idx = 0;
        if (n == 0) return -1;
        if (n > 1) return -2;
        for (int i = 0; i < 16; i++) if (k[i]) idx = i;
        return idx;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_code  = 0;
        m_pulso = 0;
        m_hist.delete();
    endtask

    task automatic model_frame(input logic [15:0] k);
        int r = classify(k);
        bit stable = 1;
        m_hist.push_back(r);
        if (m_hist.size() > DEBOUNCE) void'(m_hist.pop_front());
        m_pulso = 0;
        foreach (m_hist[i]) if (m_hist[i] != r) stable = 0;
        if (stable && m_hist.size() == DEBOUNCE) begin
            case (m_state)
                0: if (r >= 0) begin m_state = 1; m_code = r; m_pulso = 1; end
                   else if (r == -2) m_state = 2;
                1: if (r == -1) m_state = 0;
                   else if (r == -2) m_state = 2;
                   else if (r != m_code) begin m_code = r; m_pulso = 1; end
                default: if (r == -1) m_state = 0;
            endcase
        end
    endtask

    // Called #1 after a frame boundary; returns #1 after the next one
    task automatic run_frame(input logic [15:0] k);
        int stray = 0;
        keys = k;
        repeat (15) begin
            @(posedge clk); #1;
            if (pulso) stray++;
        end
        @(posedge clk); #1;
        chk("stray_pulso", 32'(stray), 32'd0);
    endtask

    task automatic do_reset(input bit check_rot);
        rst  = 1'b1;
        keys = 16'($urandom());
        repeat (5) @(posedge clk);
        #1;
        chk("rst_col", 32'(col), 32'd1);
        chk_outs("rst", 0, 0, 0, 0);
        rst  = 1'b0;
        keys = '0;
        if (check_rot) begin
            repeat (3) @(posedge clk);
            #1 chk("rot_hold", 32'(col), 32'd1);
            @(posedge clk);
            #1 chk("rot_next", 32'(col), 32'd2);
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] k;
        int pc;
        rst  = 1'b1;
        keys = '0;
        do_reset(1);

        // press/release, multi-key lockout, rollover, same-column multi
        tbl.push_back('{16'h0040, 0, 0, 0, 0});
        tbl.push_back('{16'h0040, 0, 0, 0, 0});
        tbl.push_back('{16'h0040, 1, 0, 6, 1});
        tbl.push_back('{16'h0040, 1, 0, 6, 0});
        tbl.push_back('{16'h0000, 1, 0, 6, 0});
        tbl.push_back('{16'h0000, 1, 0, 6, 0});
        tbl.push_back('{16'h0000, 0, 0, 6, 0});
        tbl.push_back('{16'h2001, 0, 0, 6, 0});
        tbl.push_back('{16'h2001, 0, 0, 6, 0});
        tbl.push_back('{16'h2001, 0, 1, 6, 0});
        tbl.push_back('{16'h0001, 0, 1, 6, 0});
        tbl.push_back('{16'h0001, 0, 1, 6, 0});
        tbl.push_back('{16'h0001, 0, 1, 6, 0});
        tbl.push_back('{16'h0000, 0, 1, 6, 0});
        tbl.push_back('{16'h0000, 0, 1, 6, 0});
        tbl.push_back('{16'h0000, 0, 0, 6, 0});
        tbl.push_back('{16'h0020, 0, 0, 6, 0});
        tbl.push_back('{16'h0020, 0, 0, 6, 0});
        tbl.push_back('{16'h0020, 1, 0, 5, 1});
        tbl.push_back('{16'h0200, 1, 0, 5, 0});
        tbl.push_back('{16'h0200, 1, 0, 5, 0});
        tbl.push_back('{16'h0200, 1, 0, 9, 1});
        tbl.push_back('{16'h0000, 1, 0, 9, 0});
        tbl.push_back('{16'h0000, 1, 0, 9, 0});
        tbl.push_back('{16'h0000, 0, 0, 9, 0});
        tbl.push_back('{16'h0003, 0, 0, 9, 0});
        tbl.push_back('{16'h0003, 0, 0, 9, 0});
        tbl.push_back('{16'h0003, 0, 1, 9, 0});
        tbl.push_back('{16'h0000, 0, 1, 9, 0});
        tbl.push_back('{16'h0000, 0, 1, 9, 0});
        tbl.push_back('{16'h0000, 0, 0, 9, 0});
        foreach (tbl[i]) begin
            run_frame(tbl[i].k);
            chk_outs($sformatf("tbl%0d", i), tbl[i].tv, tbl[i].mu, int'(tbl[i].code), tbl[i].p);
        end

        // bounce: key 6 toggling every 10 cycles for 5 frames, then held
        keys = 16'h0040;
        pc = 0;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk); #1;
            if (pulso) pc++;
            if (e % 10 == 0 && e < 80) keys = keys ^ 16'h0040;
        end
        chk("bounce_no_pulso", 32'(pc), 32'd0);
        pc = 0;
        repeat (4) begin
            run_frame(16'h0040);
            if (pulso) pc++;
        end
        chk("bounce_one_pulso", 32'(pc), 32'd1);
        chk("bounce_tv", 32'(tecla_valida), 32'd1);
        chk("bounce_code", 32'(codigo), 32'd6);

        // reset mid-frame during debounce of key 6
        do_reset(0);
        model_reset();
        repeat (2) begin
            run_frame(16'h0040);
            model_frame(16'h0040);
            chk_outs("pre_rst", m_state == 1, m_state == 2, m_code, m_pulso);
        end
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_outs("mid_rst", 0, 0, 0, 0);
        model_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(16'h0040);
            model_frame(16'h0040);
            chk_outs($sformatf("post_rst%0d", f), m_state == 1, m_state == 2, m_code, m_pulso);
        end
        chk("post_rst_pulso", 32'(pulso), 32'd1);

        // randomized frames against the reference model
        do_reset(0);
        model_reset();
        k = '0;
        for (int f = 0; f < 60; f++) begin
            int sel = int'($urandom_range(0, 9));
            if (sel >= 4 && sel <= 5) k = '0;
            else if (sel >= 6 && sel <= 8) k = 16'(1) << $urandom_range(0, 15);
            else if (sel == 9) k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            run_frame(k);
            model_frame(k);
            chk_outs($sformatf("rnd%0d", f), m_state == 1, m_state == 2, m_code, m_pulso);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/teclado_escaner.md
# teclado_escaner

Parametrised matrix-keypad scanner with debounce, multi-key detection and a single-cycle press strobe. Drives one-hot column strobes, samples row inputs, and reports a debounced key code for downstream control logic (display, calculator/command FSM). Generalises 4x4 scanning to FILAS x COLS and adds a synchronous reset, debounce, rollover lockout and event signalling.

## Interface
- FILAS, 4: number of row inputs (>=1).
- COLS, 4: number of column drive outputs (>=2).
- SCAN_DIV, 1000: clk cycles per column slot (>=2).
- DEBOUNCE, 4: consecutive identical frame results required to accept a change (1..255).
- CODE_W, $clog2(FILAS*COLS): key-code width (derived, not overridden).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fila  in  FILAS  row inputs, active-high, asynchronous to clk.
- col  out  COLS  one-hot column drive.
- codigo  out  CODE_W  last accepted key code.
- tecla_valida  out  1  high while exactly one debounced key is held.
- pulso  out  1  one-cycle strobe on each newly accepted key.
- multiple  out  1  high while a debounced multi-key condition holds.

## Operation
- fila passes through a 2-flop synchroniser before any use.
- Slot counter 0..SCAN_DIV-1; column index 0..COLS-1 advances on slot wrap; col = 1<<index, wraps COLS-1 -> 0.
- Rows sampled only in the last cycle of each slot (SCAN_DIV-1) to allow settling.
- Frame = COLS slots. Per frame, accumulate: hit count (saturating at 2) and code of the first hit.
- Key code = col_index*FILAS + row_index (col 0/row 0 -> 0; col 0/row 1 -> 1; col 1/row 0 -> FILAS).
- Frame result at frame end: NONE (0 hits), SINGLE(code) (exactly one row bit in exactly one column), MULTI (>=2 total bits, either in one column or across columns).
- Debounce: candidate register + counter. If result equals candidate, counter increments (saturating at DEBOUNCE); otherwise candidate <= result, counter <= 1. Candidate accepted when counter reaches DEBOUNCE and differs from accepted state.
- Accepted-state FSM:
  - IDLE: tecla_valida=0, multiple=0. Accept SINGLE(k) -> PRESSED(k), codigo<=k, pulso. Accept MULTI -> LOCK.
  - PRESSED(k): tecla_valida=1. Accept NONE -> IDLE. Accept SINGLE(j), j!=k -> PRESSED(j), codigo<=j, pulso. Accept MULTI -> LOCK.
  - LOCK: multiple=1, tecla_valida=0. Only accepted NONE -> IDLE; SINGLE ignored (rollover lockout, no pulso until full release).
- codigo holds last accepted key through IDLE and LOCK.

## Timing
- Reset values: col=1 (column 0), codigo=0, tecla_valida=0, pulso=0, multiple=0; slot/column/hit counters 0, candidate=NONE, counter=0, FSM IDLE, synchroniser flops 0.
- Reset asserted mid-frame or mid-debounce: all above restored next edge; no pulso generated; scanning restarts at column 0 slot 0 the cycle after rst deasserts.
- Frame length = COLS*SCAN_DIV cycles.
- Frame result evaluated in the last cycle of column COLS-1; FSM/outputs update on the following edge; pulso high exactly that one cycle.
- Latency: key stable (post-synchroniser) from a frame start -> pulso at end of DEBOUNCE-th frame + 1 cycle. Input-to-pulso worst case (DEBOUNCE+1)*COLS*SCAN_DIV + 3 cycles.
- tecla_valida/multiple change on the same edge as the FSM transition.
- Release latency: DEBOUNCE frames of NONE + 1 cycle.
- Any frame result differing from the candidate resets the count; bouncing never produces pulso.

## Test plan
Parameters FILAS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3 (frame = 16 cycles).
- Reset: hold rst 5 cycles with random fila -> col=4'b0001, codigo=0, tecla_valida=0, pulso=0, multiple=0; col rotates 0001->0010 four cycles after release.
- Single press: assert fila[2] whenever col[1]=1 (code 6), held 10 frames -> exactly one pulso, codigo=6, tecla_valida=1 from frame-3 end +1 cycle; release -> tecla_valida=0 three frames later, codigo stays 6.
- Bounce: toggle key 6 every 10 cycles for 5 frames then hold stable -> no pulso during bounce; one pulso 3 frames after stabilisation.
- Multi-key: key 0 (col0,row0) plus key 13 (col3,row1) held -> multiple=1, no pulso; drop key 13, keep key 0 -> still LOCK, no pulso; release all -> multiple=0 after 3 NONE frames.
- Rollover: hold key 5 until accepted, then switch to key 9 without gap -> two pulsos, codigo 5 then 9, tecla_valida continuously 1.
- Reset mid-debounce: key 6 stable 2 frames, pulse rst 1 cycle -> no pulso; pulso occurs 3 full frames after rst release.
